// File: rtl/camera_capture_source.sv
// Captures a parallel camera sensor bus into a SOF/EOL/EOF-tagged valid/ready stream.
// A small FIFO absorbs consumer stalls; overflow truncates the frame until the next FVAL edge.
module camera_capture_source #(
    parameter int P_DATA_W = 12,
    parameter int P_WIDTH  = 640,
    parameter int P_HEIGHT = 480,
    parameter int P_DEPTH  = 16
) (
    input  logic                ul1Clock,
    input  logic                ul1ResetN,
    input  logic                ul1Enable,
    input  logic                ul1ClearErr,
    input  logic                ul1SensFval,
    input  logic                ul1SensLval,
    input  logic                ul1SensPixEn,
    input  logic [P_DATA_W-1:0] ulSensData,
    output logic                ul1Valid,
    input  logic                ul1Ready,
    output logic [P_DATA_W-1:0] ulData,
    output logic                ul1Sof,
    output logic                ul1Eol,
    output logic                ul1Eof,
    output logic                ul1Busy,
    output logic                ul1Overflow,
    output logic                ul1SizeErr,
    output logic [15:0]         ulFrameCnt
);
    localparam int CW = $clog2(P_WIDTH + 1);
    localparam int RW = $clog2(P_HEIGHT + 1);
    localparam int AW = $clog2(P_DEPTH);
    localparam logic [CW-1:0] WIDTH_C  = CW'(P_WIDTH);
    localparam logic [CW-1:0] LAST_COL = CW'(P_WIDTH - 1);
    localparam logic [RW-1:0] HEIGHT_C = RW'(P_HEIGHT);
    localparam logic [RW-1:0] LAST_ROW = RW'(P_HEIGHT - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(P_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FRAME, S_DROP} state_t;

    typedef struct packed {
        logic [P_DATA_W-1:0] data;
        logic                sof;
        logic                eol;
        logic                eof;
    } word_t;

    state_t        state_q;
    logic          prev_fval_q, prev_lval_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q, row_d;
    logic          wr_vld_q;
    word_t         wr_word_q;
    word_t         mem_q [P_DEPTH];
    word_t         rd_word;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q, cnt_d;
    logic          ovf_q, serr_q;
    logic [15:0]   fcnt_q;

    logic sample, fval_rise, fval_fall, lval_fall;
    logic in_frame, pix_in, in_range;
    logic ovf_evt, wr_ok, rd_en, serr_evt;

    assign sample    = ul1SensPixEn;
    assign fval_rise = sample & ul1SensFval & ~prev_fval_q;
    assign fval_fall = sample & ~ul1SensFval & prev_fval_q;
    assign lval_fall = sample & ~ul1SensLval & prev_lval_q;
    assign in_frame  = (state_q == S_FRAME);
    assign pix_in    = in_frame & sample & ul1SensFval & ul1SensLval;
    assign in_range  = (col_q < WIDTH_C) && (row_q < HEIGHT_C);

    // A word registered in the overflow cycle is discarded once in DROP, keeping the truncated
    // frame from resuming mid-stream when the consumer frees space.
    assign ovf_evt = wr_vld_q && (state_q != S_DROP) && (cnt_q == DEPTH_C);
    assign wr_ok   = wr_vld_q && (state_q != S_DROP) && (cnt_q != DEPTH_C);
    assign rd_en   = ul1Valid & ul1Ready;

    always_comb begin
        row_d = row_q;
        if (lval_fall && (col_q != '0) && (row_q < HEIGHT_C))
            row_d = row_q + 1'b1;
    end

    assign serr_evt = (pix_in & ~in_range)
                    | (in_frame & lval_fall & (col_q != '0) & (col_q < WIDTH_C))
                    | (in_frame & fval_fall & (row_d < HEIGHT_C));

    always_comb begin
        cnt_d = cnt_q;
        if (wr_ok && !rd_en)
            cnt_d = cnt_q + 1'b1;
        else if (!wr_ok && rd_en)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge ul1Clock) begin
        if (!ul1ResetN) begin
            state_q     <= S_IDLE;
            prev_fval_q <= 1'b1;
            prev_lval_q <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            wr_vld_q    <= 1'b0;
            wr_word_q   <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            serr_q      <= 1'b0;
            fcnt_q      <= '0;
        end else begin
            if (sample) begin
                prev_fval_q <= ul1SensFval;
                prev_lval_q <= ul1SensLval;
            end

            case (state_q)
                S_IDLE: begin
                    if (fval_rise && ul1Enable) begin
                        state_q <= S_FRAME;
                        col_q   <= '0;
                        row_q   <= '0;
                    end
                end
                S_FRAME: begin
                    if (ovf_evt)
                        state_q <= S_DROP;
                    else if (fval_fall)
                        state_q <= S_IDLE;
                    row_q <= row_d;
                    if (lval_fall)
                        col_q <= '0;
                    else if (pix_in && (col_q < WIDTH_C))
                        col_q <= col_q + 1'b1;
                end
                S_DROP: begin
                    if (sample && !ul1SensFval)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase

            wr_vld_q <= pix_in & in_range;
            if (pix_in && in_range) begin
                wr_word_q.data <= ulSensData;
                wr_word_q.sof  <= (row_q == '0) && (col_q == '0);
                wr_word_q.eol  <= (col_q == LAST_COL);
                wr_word_q.eof  <= (col_q == LAST_COL) && (row_q == LAST_ROW);
            end

            if (wr_ok)
                wptr_q <= wptr_q + 1'b1;
            if (rd_en)
                rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_d;

            if (wr_ok && wr_word_q.eof)
                fcnt_q <= fcnt_q + 1'b1;

            if (ovf_evt)
                ovf_q <= 1'b1;
            else if (ul1ClearErr)
                ovf_q <= 1'b0;

            if (serr_evt)
                serr_q <= 1'b1;
            else if (ul1ClearErr)
                serr_q <= 1'b0;
        end
    end

    always_ff @(posedge ul1Clock) begin
        if (wr_ok)
            mem_q[wptr_q] <= wr_word_q;
    end

    assign rd_word     = mem_q[rptr_q];
    assign ul1Valid    = (cnt_q != '0);
    assign ulData      = ul1Valid ? rd_word.data : '0;
    assign ul1Sof      = ul1Valid & rd_word.sof;
    assign ul1Eol      = ul1Valid & rd_word.eol;
    assign ul1Eof      = ul1Valid & rd_word.eof;
    assign ul1Busy     = (state_q != S_IDLE);
    assign ul1Overflow = ovf_q;
    assign ul1SizeErr  = serr_q;
    assign ulFrameCnt  = fcnt_q;

endmodule

// File: tb/tb_camera_capture_source.sv
// Directed bench for camera_capture_source with a 4x2 frame and a 4-entry FIFO.
module tb_camera_capture_source;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rstn, en, clr, fv, lv, pe, rdy;
    logic [DW-1:0] sd;
    logic          vld, sof, eol, eof, busy, ovf, serr;
    logic [DW-1:0] data;
    logic [15:0]   fcnt;
    logic [14:0]   mon_word;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int first_valid_cyc = -1;
    int first_pix_cyc = 0;
    int hold_obs = 0;
    int hold_viol = 0;
    logic hold_pend = 1'b0;
    logic [14:0] hold_word = '0;
    bit tog = 1'b0;
    logic [14:0] cap[$];
    logic [14:0] expq[$];

    camera_capture_source #(
        .P_DATA_W(DW), .P_WIDTH(4), .P_HEIGHT(2), .P_DEPTH(4)
    ) dut (
        .ul1Clock(clk), .ul1ResetN(rstn), .ul1Enable(en), .ul1ClearErr(clr),
        .ul1SensFval(fv), .ul1SensLval(lv), .ul1SensPixEn(pe), .ulSensData(sd),
        .ul1Valid(vld), .ul1Ready(rdy), .ulData(data), .ul1Sof(sof), .ul1Eol(eol),
        .ul1Eof(eof), .ul1Busy(busy), .ul1Overflow(ovf), .ul1SizeErr(serr),
        .ulFrameCnt(fcnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign mon_word = {data, sof, eol, eof};

    // Stream monitor: collects transfers and watches that a stalled word stays put.
    always @(negedge clk) begin
        if (hold_pend) begin
            hold_obs <= hold_obs + 1;
            if (!(vld && mon_word == hold_word))
                hold_viol <= hold_viol + 1;
        end
        hold_pend <= vld && !rdy;
        hold_word <= mon_word;
        if (vld && rdy)
            cap.push_back(mon_word);
        if (vld && first_valid_cyc < 0)
            first_valid_cyc <= cyc;
    end

    function automatic logic [14:0] wd(input int d, input logic s, input logic l, input logic e);
        logic [31:0] dv;
        dv = d;
        return {dv[DW-1:0], s, l, e};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (tog) rdy = ~rdy;
    endtask

    task automatic sample(input logic f, input logic l, input int d, input int gap);
        logic [31:0] dv;
        dv = d;
        fv = f; lv = l; sd = dv[DW-1:0]; pe = 1'b1;
        step();
        pe = 1'b0;
        repeat (gap) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0; pe = 1'b0; fv = 1'b0; lv = 1'b0; clr = 1'b0;
        step(); step();
        rstn = 1'b1;
        cap.delete();
        expq.delete();
    endtask

    // Two lines of len0 and len1 pixels; Enable is set to en_after between the lines.
    task automatic frame(input int len0, input int len1, input int gap, input int base,
                         input logic en_after);
        int d;
        d = base;
        sample(1'b0, 1'b0, 0, gap);
        sample(1'b1, 1'b0, 0, gap);
        first_pix_cyc = cyc;
        for (int i = 0; i < len0; i++) begin sample(1'b1, 1'b1, d, gap); d++; end
        sample(1'b1, 1'b0, 0, gap);
        en = en_after;
        for (int i = 0; i < len1; i++) begin sample(1'b1, 1'b1, d, gap); d++; end
        sample(1'b1, 1'b0, 0, gap);
    endtask

    task automatic end_frame(input int gap);
        sample(1'b0, 1'b0, 0, gap);
        sample(1'b0, 1'b0, 0, 0);
    endtask

    task automatic drain();
        tog = 1'b0;
        rdy = 1'b1;
        repeat (12) step();
    endtask

    task automatic exp_frame(input int base);
        for (int i = 0; i < 8; i++)
            expq.push_back(wd(base + i, i == 0, (i % 4) == 3, i == 7));
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_len"}, cap.size(), expq.size());
        for (int i = 0; i < expq.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), (i < cap.size()) ? {17'd0, cap[i]} : 'x, {17'd0, expq[i]});
        cap.delete();
        expq.delete();
    endtask

    initial begin
        rstn = 1'b0; en = 1'b1; clr = 1'b0; fv = 1'b0; lv = 1'b0; pe = 1'b0; rdy = 1'b1; sd = '0;

        // Reset state
        do_reset();
        chk("rst_flags", {25'd0, vld, sof, eol, eof, busy, ovf, serr}, 0);
        chk("rst_data", {20'd0, data}, 0);
        chk("rst_fcnt", {16'd0, fcnt}, 0);

        // 1: nominal frame, continuous strobe, Ready=1
        first_valid_cyc = -1;
        frame(4, 4, 0, 0, 1'b1);
        end_frame(0);
        drain();
        chk("t1_latency", first_valid_cyc - first_pix_cyc, 2);
        exp_frame(0);
        chk_stream("t1");
        chk("t1_fcnt", {16'd0, fcnt}, 1);
        chk("t1_errs", {30'd0, ovf, serr}, 0);
        chk("t1_busy", {31'd0, busy}, 0);

        // 2: sparse strobe, Ready toggling
        do_reset();
        hold_obs = 0; hold_viol = 0;
        rdy = 1'b1; tog = 1'b1;
        frame(4, 4, 2, 0, 1'b1);
        end_frame(2);
        drain();
        exp_frame(0);
        chk_stream("t2");
        chk("t2_fcnt", {16'd0, fcnt}, 1);
        chk("t2_errs", {30'd0, ovf, serr}, 0);
        chk("t2_hold_seen", {31'd0, hold_obs > 0}, 1);
        chk("t2_hold_viol", hold_viol, 0);

        // 3: overflow with Ready held low
        do_reset();
        rdy = 1'b0;
        frame(4, 4, 0, 0, 1'b1);
        chk("t3_ovf", {31'd0, ovf}, 1);
        chk("t3_busy_drop", {31'd0, busy}, 1);
        chk("t3_valid", {31'd0, vld}, 1);
        chk("t3_none_taken", cap.size(), 0);
        end_frame(0);
        chk("t3_busy_idle", {31'd0, busy}, 0);
        drain();
        for (int i = 0; i < 4; i++) expq.push_back(wd(i, i == 0, i == 3, 1'b0));
        chk_stream("t3_trunc");
        chk("t3_fcnt0", {16'd0, fcnt}, 0);
        chk("t3_serr", {31'd0, serr}, 0);
        frame(4, 4, 0, 16, 1'b1);
        end_frame(0);
        drain();
        exp_frame(16);
        chk_stream("t3_next");
        chk("t3_fcnt1", {16'd0, fcnt}, 1);
        chk("t3_ovf_sticky", {31'd0, ovf}, 1);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t3_ovf_clr", {31'd0, ovf}, 0);

        // 4: short first line
        do_reset();
        frame(3, 4, 0, 0, 1'b1);
        end_frame(0);
        drain();
        expq.push_back(wd(0, 1'b1, 1'b0, 1'b0));
        expq.push_back(wd(1, 1'b0, 1'b0, 1'b0));
        expq.push_back(wd(2, 1'b0, 1'b0, 1'b0));
        expq.push_back(wd(3, 1'b0, 1'b0, 1'b0));
        expq.push_back(wd(4, 1'b0, 1'b0, 1'b0));
        expq.push_back(wd(5, 1'b0, 1'b0, 1'b0));
        expq.push_back(wd(6, 1'b0, 1'b1, 1'b1));
        chk_stream("t4");
        chk("t4_serr", {31'd0, serr}, 1);
        chk("t4_ovf", {31'd0, ovf}, 0);
        clr = 1'b1; step(); clr = 1'b0;
        chk("t4_serr_clr", {31'd0, serr}, 0);

        // 5: Enable low at frame start, then Enable dropped mid-frame
        do_reset();
        en = 1'b0;
        frame(4, 4, 0, 0, 1'b0);
        chk("t5_busy_off", {31'd0, busy}, 0);
        end_frame(0);
        drain();
        chk_stream("t5_off");
        chk("t5_fcnt0", {16'd0, fcnt}, 0);
        en = 1'b1;
        frame(4, 4, 0, 8, 1'b0);
        end_frame(0);
        drain();
        exp_frame(8);
        chk_stream("t5_mid");
        chk("t5_fcnt1", {16'd0, fcnt}, 1);
        en = 1'b1;

        // 6: reset mid-frame, released with FVAL high
        do_reset();
        sample(1'b0, 1'b0, 0, 0);
        sample(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 4; i++) sample(1'b1, 1'b1, i, 0);
        sample(1'b1, 1'b0, 0, 0);
        sample(1'b1, 1'b1, 4, 0);
        rstn = 1'b0;
        sample(1'b1, 1'b1, 5, 0);
        sample(1'b1, 1'b1, 6, 0);
        rstn = 1'b1;
        cap.delete();
        sample(1'b1, 1'b1, 7, 0);
        sample(1'b1, 1'b0, 0, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_valid", {31'd0, vld}, 0);
        end_frame(0);
        drain();
        chk_stream("t6_ignored");
        chk("t6_fcnt0", {16'd0, fcnt}, 0);
        frame(4, 4, 0, 40, 1'b1);
        end_frame(0);
        drain();
        exp_frame(40);
        chk_stream("t6_full");
        chk("t6_fcnt1", {16'd0, fcnt}, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
